// File: rtl/fec_sched_pkg.sv
// Shared types and constants for the FEC frame scheduler and its coefficient bank.
package fec_sched_pkg;

    localparam int M      = 3;
    localparam int WIDTH  = 11;
    localparam int DATA_W = WIDTH - 1;
    localparam int NSETS  = 4;
    localparam int SET_W  = $clog2(NSETS);
    localparam int IDX_W  = $clog2(M);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    // Indexed [row][col]
    typedef logic [M-1:0][M-1:0][WIDTH-1:0] coeff_mat_t;
    typedef logic [M-1:0][DATA_W-1:0]       sym_vec_t;

    function automatic coeff_mat_t IDENTITY_COEFF();
        coeff_mat_t m;
        m = {(M*M*WIDTH){1'b0}};
        for (int i = 0; i < M; i++) begin
            m[i][i] = WIDTH'(1);
        end
        return m;
    endfunction

endpackage

// File: rtl/fec_coeff_bank.sv
// Encode/decode coefficient matrices for NSETS sets, with a guarded write port
// and a read port that follows the scheduler's active set.
module fec_coeff_bank
    import fec_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_enc,
    input  logic [SET_W-1:0]  cfg_set,
    input  logic [IDX_W-1:0]  cfg_row,
    input  logic [IDX_W-1:0]  cfg_col,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic [SET_W-1:0]  active_set,
    input  logic              busy,
    output logic              cfg_err,
    output coeff_mat_t        enc_co,
    output coeff_mat_t        dec_co
);

    coeff_mat_t enc_r [NSETS];
    coeff_mat_t dec_r [NSETS];
    logic       cfg_err_r;
    logic       reject_s;
    logic       accept_s;

    // Reject writes outside the matrix or into the set a frame is using
    always_comb begin
        reject_s = 1'b0;
        accept_s = 1'b0;
        if (cfg_we) begin
            if ((int'(cfg_row) >= M) || (int'(cfg_col) >= M) ||
                (busy && (cfg_set == active_set))) begin
                reject_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            reject_s = 1'b0;
        end
    end

    // Bank storage and reject pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSETS; s++) begin
                enc_r[s] <= IDENTITY_COEFF();
                dec_r[s] <= IDENTITY_COEFF();
            end
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= reject_s;
            if (accept_s && cfg_enc) begin
                enc_r[cfg_set][cfg_row][cfg_col] <= cfg_data;
            end else if (accept_s) begin
                dec_r[cfg_set][cfg_row][cfg_col] <= cfg_data;
            end
        end
    end

    // Active-set read port
    always_comb begin
        enc_co  = enc_r[active_set];
        dec_co  = dec_r[active_set];
        cfg_err = cfg_err_r;
    end

endmodule

// File: rtl/fec_frame_sched.sv
// Frame sequencer: collects M symbols, drives the codec with the selected coefficient
// set and streams the registered result. FEC_SCHED_STATS_EN adds frame/reject counters.
module fec_frame_sched
    import fec_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SET_W-1:0]  in_set,
    input  logic              cfg_we,
    input  logic              cfg_enc,
    input  logic [SET_W-1:0]  cfg_set,
    input  logic [IDX_W-1:0]  cfg_row,
    input  logic [IDX_W-1:0]  cfg_col,
    input  logic [WIDTH-1:0]  cfg_data,
    output logic              cfg_err,
    output sym_vec_t          codec_sym_in,
    output coeff_mat_t        codec_dec_co,
    output coeff_mat_t        codec_enc_co,
    input  sym_vec_t          codec_sym_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy
`ifdef FEC_SCHED_STATS_EN
    ,
    output logic [31:0]       frames_done,
    output logic [15:0]       cfg_rejects
`endif
);

    state_e           state_r, state_s;
    logic [IDX_W-1:0] cnt_r, cnt_s;
    logic [SET_W-1:0] active_set_r;
    sym_vec_t         slot_r;
    sym_vec_t         buf_r;
    logic             in_hs_s, out_hs_s, last_s;

    // Stream handshakes and output decode from state registers
    always_comb begin
        in_ready  = (state_r == COLLECT);
        out_valid = (state_r == DRAIN);
        last_s    = (cnt_r == IDX_W'(M - 1));
        in_hs_s   = in_valid && in_ready;
        out_hs_s  = out_ready && out_valid;
        busy      = (state_r != COLLECT) || (cnt_r != IDX_W'(0));
        out_last  = out_valid && last_s;
        if (out_valid) begin
            out_data = buf_r[cnt_r];
        end else begin
            out_data = DATA_W'(0);
        end
    end

    // Next-state and symbol counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            COLLECT: begin
                if (in_hs_s && last_s) begin
                    state_s = COMPUTE;
                    cnt_s   = IDX_W'(0);
                end else if (in_hs_s) begin
                    cnt_s = cnt_r + IDX_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            COMPUTE: begin
                state_s = DRAIN;
                cnt_s   = IDX_W'(0);
            end
            DRAIN: begin
                if (out_hs_s && last_s) begin
                    state_s = COLLECT;
                    cnt_s   = IDX_W'(0);
                end else if (out_hs_s) begin
                    cnt_s = cnt_r + IDX_W'(1);
                end else begin
                    cnt_s = cnt_r;
                end
            end
            default: begin
                state_s = COLLECT;
                cnt_s   = IDX_W'(0);
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= COLLECT;
            cnt_r   <= IDX_W'(0);
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Input slots, active set latch and result buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r       <= {(M*DATA_W){1'b0}};
            buf_r        <= {(M*DATA_W){1'b0}};
            active_set_r <= SET_W'(0);
        end else begin
            if (in_hs_s) begin
                slot_r[cnt_r] <= in_data;
            end
            if (in_hs_s && (cnt_r == IDX_W'(0))) begin
                active_set_r <= in_set;
            end
            if (state_r == COMPUTE) begin
                buf_r <= codec_sym_out;
            end
        end
    end

    always_comb begin
        codec_sym_in = slot_r;
    end

    fec_coeff_bank u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_enc    (cfg_enc),
        .cfg_set    (cfg_set),
        .cfg_row    (cfg_row),
        .cfg_col    (cfg_col),
        .cfg_data   (cfg_data),
        .active_set (active_set_r),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .enc_co     (codec_enc_co),
        .dec_co     (codec_dec_co)
    );

`ifdef FEC_SCHED_STATS_EN
    logic [31:0] frames_done_r;
    logic [15:0] cfg_rejects_r;

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_done_r <= 32'd0;
            cfg_rejects_r <= 16'd0;
        end else begin
            if (out_hs_s && last_s && (frames_done_r != 32'hFFFF_FFFF)) begin
                frames_done_r <= frames_done_r + 32'd1;
            end
            if (cfg_err && (cfg_rejects_r != 16'hFFFF)) begin
                cfg_rejects_r <= cfg_rejects_r + 16'd1;
            end
        end
    end

    always_comb begin
        frames_done = frames_done_r;
        cfg_rejects = cfg_rejects_r;
    end
`endif

endmodule
